// File: rtl/serial_deframer_pkg.sv
// serial_deframer_pkg: FSM state encoding and width helper shared by the deframer files.
package serial_deframer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Never returns less than 1 so single-value counters still get a real bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/serial_deframer_bit_timer.sv
// bit_timer: free-running 0..BIT_CYCLES-1 bit-period counter with mid-bit strobe and end-of-bit flag.
module bit_timer
    import serial_deframer_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic                         clock_i,
    input  logic                         reset_n_i,
    input  logic                         clear_i,
    output logic [clog2(BIT_CYCLES)-1:0] count_o,
    output logic                         strobe_o,
    output logic                         bit_end_o
);

    localparam int TW = clog2(BIT_CYCLES);

    logic [TW-1:0] count_q, count_d;

    assign strobe_o  = count_q == TW'(BIT_CYCLES / 2);
    assign bit_end_o = count_q == TW'(BIT_CYCLES - 1);
    assign count_o   = count_q;

    always_comb begin
        count_d = (clear_i || bit_end_o) ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) count_q <= '0;
        else            count_q <= count_d;
    end

endmodule

// File: rtl/serial_deframer.sv
// serial_deframer: framed serial (start 1, data, [even parity], stop 0) to parallel receiver.
// Define SERIAL_DEFRAMER_PARITY_EN to expect and check an even-parity bit after the data bits.
module serial_deframer
    import serial_deframer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             serialIn,
    output logic [WIDTH-1:0] parallelOut,
    output logic             outValid,
    output logic             frameError,
    output logic             parityError,
    output logic             busy
);

`ifdef SERIAL_DEFRAMER_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    localparam int TW = clog2(BIT_CYCLES);
    localparam int IW = clog2(WIDTH);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             par_q, par_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             perr_q, perr_d;
    logic             strobe, bit_end, par_bad;
    logic [TW-1:0]    timer_cnt_unused;

    // Holding the timer clear while idle makes START always begin at count 0.
    bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
        .clock_i   (clock),
        .reset_n_i (resetN),
        .clear_i   (state_q == IDLE),
        .count_o   (timer_cnt_unused),
        .strobe_o  (strobe),
        .bit_end_o (bit_end)
    );

    assign par_bad     = PARITY_EN && ((^shift_q) ^ par_q);
    assign parallelOut = out_q;
    assign outValid    = valid_q;
    assign frameError  = ferr_q;
    assign parityError = PARITY_EN ? perr_q : 1'b0;
    assign busy        = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        out_d   = out_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        case (state_q)
            IDLE: state_d = serialIn ? START : IDLE;
            START: begin
                if (strobe && !serialIn) state_d = IDLE;
                else if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (strobe) shift_d = MSB_FIRST != 0 ? WIDTH'({shift_q, serialIn})
                                                     : WIDTH'({serialIn, shift_q} >> 1);
                if (bit_end) begin
                    state_d = idx_q == IW'(WIDTH - 1) ? (PARITY_EN ? PARITY : STOP) : DATA;
                    idx_d   = idx_q + 1'b1;
                end
            end
            PARITY: begin
                if (strobe) par_d = serialIn;
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (strobe) begin
                    state_d = IDLE;
                    ferr_d  = serialIn;
                    perr_d  = !serialIn && par_bad;
                    valid_d = !serialIn && !par_bad;
                    out_d   = valid_d ? shift_q : out_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

endmodule
